// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 4;

  // 2'd3 is unused; the controller decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cond_adder.sv
// Conditional adder: sum = acc + (en ? m : 0), carry kept in the top bit.
module cond_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] m,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  always_comb begin
    sum = {1'b0, acc} + (en ? {1'b0, m} : '0);
  end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-and-add multiplier controller: one conditional add per cycle, WIDTH cycles per product.
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;

  cond_adder #(
    .WIDTH(WIDTH)
  ) u_cond_adder (
    .acc(acc_q),
    .m  (m_q),
    .en (q_q[0]),
    .sum(sum)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Right shift of {carry, acc, q} after the conditional add.
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntLast) begin
          // Capture on entry to DONE so product is valid alongside done.
          product_d = {sum, q_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN) || (state_q == DONE);
    done    = (state_q == DONE);
    product = product_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Randomized and directed checks of seq_mul_ctrl against a cycle-countdown product model.
module tb_seq_mul_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  seq_mul_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: cycles remaining in the current operation (W+1 after acceptance), and the product.
  int             rem = 0;
  logic [2*W-1:0] pend = '0;
  logic [2*W-1:0] mprod = '0;
  bit             mdl_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      rem   = 0;
      mprod = '0;
    end else if (rem == 0) begin
      if (start) begin
        rem  = W + 1;
        pend = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      end
    end else begin
      rem = rem - 1;
      if (rem == 1) mprod = pend;
    end
    mdl_ok = 1;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("done", 32'(done), 32'(rem == 1));
      chk("product", 32'(product), 32'(mprod));
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one start, then wait (bounded) for done and check latency and the literal result.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] want, input string name);
    int n;
    bit seen;
    step();
    start = 1'b1;
    a = x;
    b = y;
    step();
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_lat"}, 32'(n), 32'(W + 1));
    chk({name, "_prod"}, 32'(product), 32'(want));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    #2;
    rst = 1'b0;

    do_mul(4'd5, 4'd3, 8'h0F, "m5x3");
    step();
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    do_mul(4'hF, 4'hF, 8'hE1, "mFxF");
    do_mul(4'h9, 4'hA, 8'h5A, "m9xA");
    do_mul(4'h0, 4'hB, 8'h00, "m0xB");
    do_mul(4'hB, 4'h0, 8'h00, "mBx0");

    // start held through RUN and DONE with operands changing.
    step();
    base = done_cnt;
    start = 1'b1;
    a = 4'd6;
    b = 4'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      a = 4'($urandom);
      b = 4'($urandom);
    end
    start = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("hold_one_done", 32'(done_cnt - base), 32'd1);
    chk("hold_prod", 32'(product), 32'h1E);

    // Back-to-back: second start lands in the cycle after done.
    do_mul(4'd6, 4'd7, 8'h2A, "b2b_6x7");
    do_mul(4'd3, 4'd3, 8'h09, "b2b_3x3");

    // Reset during the third RUN cycle.
    step();
    start = 1'b1;
    a = 4'd7;
    b = 4'd9;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = done_cnt;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_prod", 32'(product), 32'd0);
    repeat (8) step();
    chk("midrst_no_done", 32'(done_cnt - base), 32'd0);
    do_mul(4'd2, 4'd2, 8'h04, "m2x2");

    // rst and start together: rst wins.
    step();
    rst = 1'b1;
    start = 1'b1;
    a = 4'd3;
    b = 4'd3;
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_start_busy", 32'(busy), 32'd0);
    end

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      step();
      start = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 39) == 0);
      a     = 4'($urandom);
      b     = 4'($urandom);
    end
    step();
    start = 1'b0;
    rst = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
